// File: rtl/softplus_pwl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : softplus_pwl_unit
//  Brief    : Streaming piecewise softplus, y = relu(x) + off(x), in signed
//             fixed point. off(x) comes from runtime-programmable positive
//             and negative segment tables. The pipeline has valid/ready flow
//             control and saturates the output.
//             Build option SOFTPLUS_LERP_EN: linear interpolation inside a
//             segment. This adds stage S2b, so latency is 4 instead of 3.
//  Revision : 1.0  initial release
// ============================================================================
module softplus_pwl_unit #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int NSEG   = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_x,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_y,
    input  logic                        cfg_we,
    input  logic [$clog2(2*NSEG)-1:0]   cfg_addr,
    input  logic [DATA_W-1:0]           cfg_data
);

    localparam int c_KW = DATA_W - FRAC_W;
    localparam int c_IW = $clog2(NSEG);
    localparam int c_AW = $clog2(2*NSEG);
    localparam logic [DATA_W:0] c_MAX = {2'b00, {(DATA_W-1){1'b1}}};

    // Reset defaults; indices past the last listed entry repeat it
    function automatic logic [DATA_W-1:0] tp_default(input int j);
        case (j)
            0:       return DATA_W'(16'h004d);
            1:       return DATA_W'(16'h0037);
            2:       return DATA_W'(16'h001f);
            3:       return DATA_W'(16'h0010);
            4:       return DATA_W'(16'h000b);
            default: return DATA_W'(16'h0009);
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] tn_default(input int j);
        case (j)
            0:       return DATA_W'(16'h004d);
            1:       return DATA_W'(16'h0037);
            2:       return DATA_W'(16'h001f);
            3:       return DATA_W'(16'h000f);
            4:       return DATA_W'(16'h0007);
            default: return DATA_W'(16'h0002);
        endcase
    endfunction

    logic [DATA_W-1:0] r_tp [NSEG];
    logic [DATA_W-1:0] r_tn [NSEG];

    // The whole pipe freezes while the output is waiting on downstream
    logic w_stall;
    logic w_adv;
    assign w_stall   = out_valid & ~out_ready;
    assign w_adv     = ~w_stall;
    assign in_ready  = ~w_stall;

    // Table storage: reset reload, registered writes, out-of-range addresses ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NSEG; j++) begin
                r_tp[j] <= tp_default(j);
                r_tn[j] <= tn_default(j);
            end
        end else if (cfg_we) begin
            for (int j = 0; j < NSEG; j++) begin
                if (cfg_addr == c_AW'(j))        r_tp[j] <= cfg_data;
                if (cfg_addr == c_AW'(j + NSEG)) r_tn[j] <= cfg_data;
            end
        end
    end

    // ---------------- S1: segment index ----------------
    // For negative x, -k-1 equals ~k, so one magnitude path serves both halves.
    logic [c_KW-1:0] w_k;
    logic            w_neg;
    logic [c_KW-1:0] w_mag;
    logic            w_clamp;
    logic [c_IW-1:0] w_idx;

    assign w_k     = in_x[DATA_W-1:FRAC_W];
    assign w_neg   = in_x[DATA_W-1];
    assign w_mag   = w_neg ? ~w_k : w_k;
    assign w_clamp = 32'(w_mag) > 32'(NSEG - 1);
    assign w_idx   = w_clamp ? c_IW'(NSEG - 1) : w_mag[c_IW-1:0];

    logic              r_v1;
    logic [DATA_W-1:0] r_x1;
    logic              r_neg1;
    logic [c_IW-1:0]   r_idx1;
`ifdef SOFTPLUS_LERP_EN
    logic [FRAC_W-1:0] r_f1;
`endif

    // Stage 1 register: capture sample and its segment index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_x1   <= '0;
            r_neg1 <= 1'b0;
            r_idx1 <= '0;
`ifdef SOFTPLUS_LERP_EN
            r_f1   <= '0;
`endif
        end else if (w_adv) begin
            r_v1   <= in_valid;
            r_x1   <= in_x;
            r_neg1 <= w_neg;
            r_idx1 <= w_idx;
`ifdef SOFTPLUS_LERP_EN
            // Beyond the last segment the fraction carries no meaning
            r_f1   <= w_clamp ? '0 : in_x[FRAC_W-1:0];
`endif
        end
    end

    // Signals feeding the add/saturate stage
    logic              w_v_pre;
    logic [DATA_W-1:0] w_x_pre;
    logic [DATA_W-1:0] w_off_pre;

`ifdef SOFTPLUS_LERP_EN
    // ---------------- S2: base and neighbour lookup ----------------
    logic [DATA_W-1:0] w_base;
    logic [DATA_W-1:0] w_nbr;

    assign w_base = r_neg1 ? r_tn[r_idx1] : r_tp[r_idx1];
    // Positive side uses the next entry, and the top entry is its own neighbour.
    // Negative side reaches toward zero, and index 0 borrows Tp[0].
    assign w_nbr  = r_neg1
                  ? ((r_idx1 == '0) ? r_tp[0] : r_tn[r_idx1 - c_IW'(1)])
                  : ((r_idx1 == c_IW'(NSEG - 1)) ? r_tp[NSEG-1] : r_tp[r_idx1 + c_IW'(1)]);

    logic              r_v2;
    logic [DATA_W-1:0] r_x2;
    logic [DATA_W-1:0] r_base2;
    logic [DATA_W-1:0] r_nbr2;
    logic [FRAC_W-1:0] r_f2;

    // Stage 2 register: table values for the interpolation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_x2    <= '0;
            r_base2 <= '0;
            r_nbr2  <= '0;
            r_f2    <= '0;
        end else if (w_adv) begin
            r_v2    <= r_v1;
            r_x2    <= r_x1;
            r_base2 <= w_base;
            r_nbr2  <= w_nbr;
            r_f2    <= r_f1;
        end
    end

    // ---------------- S2b: interpolate ----------------
    localparam int c_PW = DATA_W + FRAC_W + 1;
    logic [DATA_W:0]          w_diff;
    logic [c_PW-1:0]          w_dext;
    logic [c_PW-1:0]          w_fext;
    logic signed [c_PW-1:0]   w_prod;
    logic [DATA_W-1:0]        w_delta;

    assign w_diff  = {r_nbr2[DATA_W-1], r_nbr2} - {r_base2[DATA_W-1], r_base2};
    assign w_dext  = {{FRAC_W{w_diff[DATA_W]}}, w_diff};
    assign w_fext  = {{(DATA_W+1){1'b0}}, r_f2};
    assign w_prod  = $signed(w_dext) * $signed(w_fext);
    assign w_delta = DATA_W'(w_prod >>> FRAC_W);

    logic              r_v2b;
    logic [DATA_W-1:0] r_x2b;
    logic [DATA_W-1:0] r_off2b;

    // Stage 2b register: interpolated offset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2b   <= 1'b0;
            r_x2b   <= '0;
            r_off2b <= '0;
        end else if (w_adv) begin
            r_v2b   <= r_v2;
            r_x2b   <= r_x2;
            r_off2b <= r_base2 + w_delta;
        end
    end

    assign w_v_pre   = r_v2b;
    assign w_x_pre   = r_x2b;
    assign w_off_pre = r_off2b;
`else
    // ---------------- S2: step lookup ----------------
    logic              r_v2;
    logic [DATA_W-1:0] r_x2;
    logic [DATA_W-1:0] r_off2;

    // Stage 2 register: table entry for the sample's segment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2   <= 1'b0;
            r_x2   <= '0;
            r_off2 <= '0;
        end else if (w_adv) begin
            r_v2   <= r_v1;
            r_x2   <= r_x1;
            r_off2 <= r_neg1 ? r_tn[r_idx1] : r_tp[r_idx1];
        end
    end

    assign w_v_pre   = r_v2;
    assign w_x_pre   = r_x2;
    assign w_off_pre = r_off2;
`endif

    // ---------------- S3: add and saturate ----------------
    logic [DATA_W-1:0] w_relu;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_y;

    assign w_relu = w_x_pre[DATA_W-1] ? '0 : w_x_pre;
    assign w_sum  = {1'b0, w_relu} + {1'b0, w_off_pre};
    assign w_y    = (w_sum > c_MAX) ? c_MAX[DATA_W-1:0] : w_sum[DATA_W-1:0];

    logic              r_v3;
    logic [DATA_W-1:0] r_y3;

    // Output register: held while the downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v3 <= 1'b0;
            r_y3 <= '0;
        end else if (w_adv) begin
            r_v3 <= w_v_pre;
            r_y3 <= w_y;
        end
    end

    assign out_valid = r_v3;
    assign out_y     = r_y3;

endmodule
`default_nettype wire

// File: tb/tb_softplus_pwl_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_softplus_pwl_unit
//  Brief    : Self-checking bench for softplus_pwl_unit with directed and
//             randomized stimulus against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_softplus_pwl_unit;

    localparam int DW = 16;
    localparam int FW = 8;
    localparam int NS = 6;
`ifdef SOFTPLUS_LERP_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_x;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_y;
    logic          cfg_we;
    logic [3:0]    cfg_addr;
    logic [DW-1:0] cfg_data;

    softplus_pwl_unit #(.DATA_W(DW), .FRAC_W(FW), .NSEG(NS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    int            mtp [NS];
    int            mtn [NS];
    logic [DW-1:0] q     [$];
    logic [DW-1:0] lit_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic load_defaults();
        int dp [6] = '{'h4d, 'h37, 'h1f, 'h10, 'h0b, 'h09};
        int dn [6] = '{'h4d, 'h37, 'h1f, 'h0f, 'h07, 'h02};
        for (int j = 0; j < NS; j++) begin
            mtp[j] = dp[(j < 6) ? j : 5];
            mtn[j] = dn[(j < 6) ? j : 5];
        end
    endtask

    function automatic int sx(input int v);
        return (v >= (1 << (DW-1))) ? v - (1 << DW) : v;
    endfunction

    // Softplus reference computed straight from the segment rules
    function automatic logic [DW-1:0] model(input logic [DW-1:0] x);
        int xi, k, m, i, off, sum;
        xi  = int'($signed(x));
        k   = xi >>> FW;
        m   = (xi >= 0) ? k : -k - 1;
        i   = (m > NS - 1) ? NS - 1 : m;
        off = (xi >= 0) ? mtp[i] : mtn[i];
`ifdef SOFTPLUS_LERP_EN
        begin
            int f, nbr;
            f = (m > NS - 1) ? 0 : (xi & ((1 << FW) - 1));
            if (xi >= 0) nbr = (i == NS - 1) ? mtp[NS-1] : mtp[i+1];
            else         nbr = (i == 0) ? mtp[0] : mtn[i-1];
            off = (off + (((sx(nbr) - sx(off)) * f) >>> FW)) & ((1 << DW) - 1);
        end
`endif
        sum = ((xi > 0) ? xi : 0) + off;
        if (sum > (1 << (DW-1)) - 1) sum = (1 << (DW-1)) - 1;
        return DW'(sum);
    endfunction

    // Scoreboard: record accepted samples, compare delivered results in order
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("spurious_valid", 32'(out_valid), 32'd0);
                else check("out_y", 32'(out_y), 32'(q.pop_front()));
            end else if (out_valid && !out_ready) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                if (q.size() != 0) check("stall_hold", 32'(out_y), 32'(q[0]));
            end
            if (in_valid && in_ready) begin
                if (lit_q.size() != 0) q.push_back(lit_q.pop_front());
                else q.push_back(model(in_x));
            end
        end
    end

    task automatic send(input logic [DW-1:0] x);
        logic acc;
        int   n;
        n = 0;
        in_valid = 1'b1;
        in_x     = x;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_chk(input logic [DW-1:0] x, input logic [DW-1:0] e);
`ifndef SOFTPLUS_LERP_EN
        lit_q.push_back(e);
`endif
        send(x);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input logic [3:0] a, input logic [DW-1:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (a < 4'(2*NS)) begin
            if (a < 4'(NS)) mtp[a] = int'(d);
            else            mtn[a - 4'(NS)] = int'(d);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin @(posedge clk); #1; end
        rst = 1'b0;
        load_defaults();
    endtask

    bit done;

    initial begin
        int lat;
        rst = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        load_defaults();
        @(posedge clk); #1;
        do_reset(3);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Latency from accept to out_valid
        in_valid = 1'b1; in_x = 16'h0100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        check("latency", 32'(lat), 32'(LAT));
        drain();

        // Back-to-back segment coverage
        send_chk(16'h0000, 16'h004d);
        send_chk(16'h0280, 16'h029f);
        send_chk(16'hFE80, 16'h0037);
        send_chk(16'h8000, 16'h0002);
        drain();

        // Saturation boundary
        send_chk(16'h7FFA, 16'h7FFF);
        send_chk(16'h7FF0, 16'h7FF9);
        drain();

        // Eight samples with a five-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 8; i++) send(16'(i * 16'h0140 - 16'h0400));
            end
            begin
                repeat (3) @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Table writes, ignored address, reset reload
        wr(4'd2, 16'h0020);
        send_chk(16'h0200, 16'h0220);
        drain();
        wr(4'd12, 16'h1234);
        send_chk(16'h0200, 16'h0220);
        send_chk(16'hFA00, 16'h0002);
        send_chk(16'h0500, 16'h0509);
        drain();
        do_reset(1);
        send_chk(16'h0200, 16'h021f);
        drain();

        // Reset with samples in flight
        send(16'h0300);
        send(16'hFF00);
        send(16'h0123);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_y", 32'(out_y), 32'd0);
        rst = 1'b0;
        load_defaults();
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (6) begin @(posedge clk); #1; end
        send_chk(16'h0100, 16'h0137);
        drain();

        // Randomized traffic, random backpressure, occasional table rewrites
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 3; w++) wr(4'($urandom_range(0, 2*NS - 1)), 16'($urandom_range(0, 16'h00ff)));
            done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 50; i++) begin
                        if ($urandom_range(0, 3) == 0) send(16'($urandom));
                        else send({4'($urandom), 12'($urandom)} >>> 4);
                        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    end
                    done = 1'b1;
                end
                begin
                    while (!done) begin
                        out_ready = ($urandom_range(0, 3) != 0);
                        @(posedge clk); #1;
                    end
                    out_ready = 1'b1;
                end
            join
            drain();
        end

        check("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
